mem_lsu: RTL and testbench
==========================

# mem_lsu

MEM-stage load/store unit for the 5-stage RISC-V pipeline. It turns the MEM-stage memory control (address from `ALUResult_M`, store data, `funct3`) into a valid/ready request on the data-memory port. It collects the read response and produces aligned, sign- or zero-extended `r_Data_M` for the MEM/WB register. It holds the pipeline (`stall_M`) until the access completes.

## Interface
- No parameters; data and address widths fixed at 32.
- Reset is synchronous and active-high on `reset`; clock is `clk`.
- `clk` in 1: clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `memRead_M` in 1: MEM-stage instruction is a load.
- `memWrite_M` in 1: MEM-stage instruction is a store.
- `funct3_M` in 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU; others treated as W.
- `addr_M` in 32: byte address (ALU result).
- `wData_M` in 32: store data, right-justified.
- `r_Data_M` out 32: load result to MEM/WB.
- `stall_M` out 1: freeze PC, IF/ID, ID/EX and EX/MEM; MEM/WB takes a bubble.
- `misaligned_M` out 1: misaligned access flag (see Configuration).
- `mem_req_valid` out 1: request valid.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_we` out 1: 1 = store.
- `mem_req_addr` out 32: word address, bits [1:0] = 00.
- `mem_req_wdata` out 32: lane-replicated store data.
- `mem_req_be` out 4: byte enables.
- `mem_rsp_valid` in 1: read data valid, one cycle pulse.
- `mem_rsp_rdata` in 32: read data word.

## Operation
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- **IDLE**
  - If (memRead_M | memWrite_M) and the access is aligned: latch addr, we, be, wdata and funct3 into request registers; go to REQ; `stall_M`=1.
  - Otherwise: `stall_M`=0.
- **REQ**
  - `mem_req_valid`=1, with request fields taken from the registers.
  - On `mem_req_ready`: store → DONE; load → WAIT_RSP.
  - `stall_M`=1.
- **WAIT_RSP**
  - On `mem_rsp_valid`: extract, extend and write `r_Data_M`; go to DONE.
  - `stall_M`=1.
- **DONE**
  - `stall_M`=0 for exactly one cycle, so the pipeline advances and MEM/WB captures the result.
  - Go to IDLE.
- Both memRead_M and memWrite_M high: load wins; store is ignored.
- **Byte enables**
  - B: 0001 << addr[1:0].
  - H: 0011 << {addr[1],1'b0}.
  - W: 1111.
- **Store wdata**
  - B: {4{wData_M[7:0]}}.
  - H: {2{wData_M[15:0]}}.
  - W: wData_M.
- **Load extract**
  - Shift `mem_rsp_rdata` right by 8*addr[1:0].
  - B/H: sign-extend from bit 7/15. BU/HU: zero-extend. W: unchanged.
- **Alignment**
  - H requires addr[0]=0; W requires addr[1:0]=00.
  - B is always aligned.
- `r_Data_M` holds its last captured value until the next load capture. Stores do not change it.
- `mem_rsp_valid` outside WAIT_RSP is ignored.
- **Reset**
  - Forces IDLE. All outputs go to 0, including `r_Data_M`, `stall_M`, `mem_req_*` and `misaligned_M`.
  - Any response from a request outstanding at reset is ignored.

## Timing
- Request fields are registered. `mem_req_valid` rises the cycle after the instruction enters MEM.
- Once `mem_req_valid`=1, the request fields stay stable until the ready handshake.
- Store, ready in REQ: `stall_M` high 2 cycles; completes in cycle 3.
- Load, ready in REQ, response the next cycle: `stall_M` high 3 cycles; `r_Data_M` is valid in DONE (cycle 4).
- Each cycle of `mem_req_ready`=0 or response delay adds one stall cycle.
- A response is accepted no earlier than the cycle after the request handshake.
- Back-to-back memory instructions: the next one is detected in IDLE on the cycle after DONE, with no extra bubble.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined**
  - A misaligned access raises `misaligned_M`=1 combinationally in IDLE.
  - No request is issued and `stall_M`=0.
  - `r_Data_M` is unchanged and the instruction passes through.
- **Undefined**
  - `misaligned_M` is tied 0.
  - Misaligned accesses proceed with addr[1:0] (H: addr[0]) forced to 0 for `mem_req_be` and for load extraction.

## Test plan
- LW at 0x100, ready immediate, rdata 0xDEADBEEF one cycle after handshake → `mem_req_addr`=0x100, be=1111; `r_Data_M`=0xDEADBEEF; `stall_M` high exactly 3 cycles.
- LB at 0x103 with rdata 0x80123456 → `r_Data_M`=0xFFFFFF80. Same access as LBU → 0x00000080.
- SH at 0x102, wData 0x1234ABCD → addr 0x100, be=1100, wdata 0xABCDABCD, we=1. `r_Data_M` unchanged; stall 2 cycles.
- LW with `mem_req_ready` low 4 cycles → valid held and addr/be stable throughout; `stall_M` high 7 cycles total.
- With `LSU_MISALIGN_TRAP_EN`, LW at 0x101 → `misaligned_M`=1, no `mem_req_valid`, `stall_M`=0.
- Reset asserted in WAIT_RSP, then `mem_rsp_valid` the next cycle → state IDLE, all outputs 0, `r_Data_M` stays 0.

Source files
------------

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: valid/ready data-memory request, aligned/extended load data, pipeline stall.
// Optional misaligned-access trap via `LSU_MISALIGN_TRAP_EN (default: misaligned offsets forced to alignment).
module mem_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead_M,
  input  logic        memWrite_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wData_M,
  output logic [31:0] r_Data_M,
  output logic        stall_M,
  output logic        misaligned_M,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_be,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        access, is_b, is_h, go;
  logic [1:0]  off_eff;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [31:0] shifted, load_val;

  assign access = memRead_M | memWrite_M;
  // funct3[1:0] selects size; 011/11x fall through to word
  assign is_b   = (funct3_M[1:0] == 2'b00);
  assign is_h   = (funct3_M[1:0] == 2'b01);

  // Effective offset also serves as the silent alignment fix when trapping is off
  assign off_eff   = is_b ? addr_M[1:0] : (is_h ? {addr_M[1], 1'b0} : 2'b00);
  assign be_nxt    = is_b ? (4'b0001 << off_eff) : (is_h ? (4'b0011 << off_eff) : 4'b1111);
  assign wdata_nxt = is_b ? {4{wData_M[7:0]}} : (is_h ? {2{wData_M[15:0]}} : wData_M);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign     = is_h ? addr_M[0] : (!is_b && (addr_M[1:0] != 2'b00));
  assign misaligned_M = (state == IDLE) && access && misalign;
  assign go           = access && !misalign;
`else
  assign misaligned_M = 1'b0;
  assign go           = access;
`endif

  assign shifted = mem_rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = shifted;
    case (f3_q[1:0])
      2'b00:   load_val = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_val = mem_rsp_rdata;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    stall_M       = 1'b0;
    mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = REQ;
          stall_M   = 1'b1;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        stall_M       = 1'b1;
        if (mem_req_ready) state_nxt = mem_req_we ? DONE : WAIT_RSP;
      end
      WAIT_RSP: begin
        stall_M = 1'b1;
        if (mem_rsp_valid) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= 32'h0;
      mem_req_wdata <= 32'h0;
      mem_req_be    <= 4'b0000;
      r_Data_M      <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        f3_q          <= funct3_M;
        off_q         <= off_eff;
        mem_req_we    <= ~memRead_M;  // load wins when both are asserted
        mem_req_addr  <= {addr_M[31:2], 2'b00};
        mem_req_wdata <= wdata_nxt;
        mem_req_be    <= be_nxt;
      end
      if (state == WAIT_RSP && mem_rsp_valid) r_Data_M <= load_val;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: drives one memory instruction at a time with a responsive memory model.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        reset, memRead_M, memWrite_M, mem_req_ready, mem_rsp_valid;
  logic [2:0]  funct3_M;
  logic [31:0] addr_M, wData_M, mem_rsp_rdata;
  logic [31:0] r_Data_M, mem_req_addr, mem_req_wdata;
  logic        stall_M, misaligned_M, mem_req_valid, mem_req_we;
  logic [3:0]  mem_req_be;

  int n_cmp = 0;
  int n_bad = 0;

  // results of the last do_access
  int          a_stalls, a_cycles, a_vcyc;
  logic [31:0] a_res, a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        a_we, a_unstable, a_timeout, a_mis;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .reset(reset), .memRead_M(memRead_M), .memWrite_M(memWrite_M),
    .funct3_M(funct3_M), .addr_M(addr_M), .wData_M(wData_M), .r_Data_M(r_Data_M),
    .stall_M(stall_M), .misaligned_M(misaligned_M), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata)
  );

  // Called at a negedge; returns at the negedge after the non-stalled cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int rdy_dly, input int rsp_dly, input logic [31:0] word);
    bit done = 0;
    bit pending = 0;
    int vcnt = 0;
    int rcnt = 0;
    memRead_M = rd; memWrite_M = wr; funct3_M = f3; addr_M = a; wData_M = wd;
    mem_rsp_rdata = word;
    a_stalls = 0; a_cycles = 0; a_vcyc = 0; a_unstable = 0; a_timeout = 1; a_mis = 0;
    a_addr = 32'h0; a_wdata = 32'h0; a_be = 4'h0; a_we = 1'b0; a_res = 32'h0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      a_cycles++;
      mem_rsp_valid = 1'b0;
      if (misaligned_M) a_mis = 1'b1;
      if (!stall_M) begin
        a_res = r_Data_M;
        a_timeout = 0;
        done = 1;
      end else begin
        a_stalls++;
        if (mem_req_valid) begin
          if (a_vcyc == 0) begin
            a_addr = mem_req_addr; a_be = mem_req_be; a_wdata = mem_req_wdata; a_we = mem_req_we;
          end else if (mem_req_addr !== a_addr || mem_req_be !== a_be ||
                       mem_req_wdata !== a_wdata || mem_req_we !== a_we) begin
            a_unstable = 1'b1;
          end
          a_vcyc++;
          mem_req_ready = (vcnt >= rdy_dly);
          if (mem_req_ready && rd) pending = 1;
          vcnt++;
        end else begin
          mem_req_ready = 1'b0;
          if (pending) begin
            if (rcnt >= rsp_dly) begin
              mem_rsp_valid = 1'b1;
              pending = 0;
            end
            rcnt++;
          end
        end
        @(negedge clk);
      end
    end
    memRead_M = 0; memWrite_M = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (stall_M !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall_M); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", mem_req_valid); end
    n_cmp++; if (r_Data_M !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", r_Data_M); end
    n_cmp++; if ({mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata} !== 69'h0) begin
      n_bad++; $display("FAIL reset_req got we=%0b be=%b addr=%h wdata=%h want all 0",
                        mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata); end
    n_cmp++; if (misaligned_M !== 1'b0) begin n_bad++; $display("FAIL reset_mis got %0b want 0", misaligned_M); end
    @(negedge clk);
  endtask

  task automatic test_lw;
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    n_cmp++; if (a_addr !== 32'h100) begin n_bad++; $display("FAIL lw_addr got %h want 00000100", a_addr); end
    n_cmp++; if (a_be !== 4'b1111) begin n_bad++; $display("FAIL lw_be got %b want 1111", a_be); end
    n_cmp++; if (a_we !== 1'b0) begin n_bad++; $display("FAIL lw_we got %0b want 0", a_we); end
    n_cmp++; if (a_res !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data got %h want deadbeef", a_res); end
    n_cmp++; if (a_stalls != 3 || a_timeout) begin n_bad++; $display("FAIL lw_stall got %0d (timeout %0b) want 3", a_stalls, a_timeout); end
  endtask

  task automatic test_load_extend;
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80123456);
    n_cmp++; if (a_res !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_data got %h want ffffff80", a_res); end
    n_cmp++; if (a_be !== 4'b1000) begin n_bad++; $display("FAIL lb_be got %b want 1000", a_be); end
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80123456);
    n_cmp++; if (a_res !== 32'h00000080) begin n_bad++; $display("FAIL lbu_data got %h want 00000080", a_res); end
    do_access(1, 0, 3'b000, 32'h100, 32'h0, 0, 0, 32'h80123456);
    n_cmp++; if (a_res !== 32'h00000056) begin n_bad++; $display("FAIL lb0_data got %h want 00000056", a_res); end
    do_access(1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80123456);
    n_cmp++; if (a_res !== 32'hFFFF8012) begin n_bad++; $display("FAIL lh_data got %h want ffff8012", a_res); end
    n_cmp++; if (a_be !== 4'b1100) begin n_bad++; $display("FAIL lh_be got %b want 1100", a_be); end
    do_access(1, 0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80123456);
    n_cmp++; if (a_res !== 32'h00008012) begin n_bad++; $display("FAIL lhu_data got %h want 00008012", a_res); end
  endtask

  task automatic test_store;
    do_access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 32'hFFFFFFFF);
    n_cmp++; if (a_addr !== 32'h100) begin n_bad++; $display("FAIL sh_addr got %h want 00000100", a_addr); end
    n_cmp++; if (a_be !== 4'b1100) begin n_bad++; $display("FAIL sh_be got %b want 1100", a_be); end
    n_cmp++; if (a_wdata !== 32'hABCDABCD) begin n_bad++; $display("FAIL sh_wdata got %h want abcdabcd", a_wdata); end
    n_cmp++; if (a_we !== 1'b1) begin n_bad++; $display("FAIL sh_we got %0b want 1", a_we); end
    n_cmp++; if (a_stalls != 2 || a_timeout) begin n_bad++; $display("FAIL sh_stall got %0d want 2", a_stalls); end
    n_cmp++; if (r_Data_M !== 32'h00008012) begin n_bad++; $display("FAIL sh_rdata_hold got %h want 00008012", r_Data_M); end
    do_access(0, 1, 3'b000, 32'h101, 32'h000000AB, 0, 0, 32'h0);
    n_cmp++; if (a_be !== 4'b0010) begin n_bad++; $display("FAIL sb_be got %b want 0010", a_be); end
    n_cmp++; if (a_wdata !== 32'hABABABAB) begin n_bad++; $display("FAIL sb_wdata got %h want abababab", a_wdata); end
    do_access(0, 1, 3'b010, 32'h1F0, 32'hCAFEF00D, 0, 0, 32'h0);
    n_cmp++; if (a_wdata !== 32'hCAFEF00D || a_be !== 4'b1111) begin
      n_bad++; $display("FAIL sw_req got wdata=%h be=%b want cafef00d 1111", a_wdata, a_be); end
  endtask

  task automatic test_delays;
    do_access(1, 0, 3'b010, 32'h204, 32'h0, 4, 0, 32'h0BADF00D);
    n_cmp++; if (a_vcyc != 5) begin n_bad++; $display("FAIL rdy_valid_cycles got %0d want 5", a_vcyc); end
    n_cmp++; if (a_unstable !== 1'b0) begin n_bad++; $display("FAIL rdy_stable got unstable=%0b want 0", a_unstable); end
    n_cmp++; if (a_addr !== 32'h204) begin n_bad++; $display("FAIL rdy_addr got %h want 00000204", a_addr); end
    n_cmp++; if (a_stalls != 7) begin n_bad++; $display("FAIL rdy_stall got %0d want 7", a_stalls); end
    n_cmp++; if (a_res !== 32'h0BADF00D) begin n_bad++; $display("FAIL rdy_data got %h want 0badf00d", a_res); end
    do_access(1, 0, 3'b010, 32'h8, 32'h0, 0, 2, 32'h13579BDF);
    n_cmp++; if (a_stalls != 5 || a_res !== 32'h13579BDF) begin
      n_bad++; $display("FAIL rsp_delay got stall=%0d data=%h want 5 13579bdf", a_stalls, a_res); end
  endtask

  task automatic test_load_wins;
    do_access(1, 1, 3'b010, 32'h40, 32'h55555555, 0, 0, 32'h2468ACE0);
    n_cmp++; if (a_we !== 1'b0) begin n_bad++; $display("FAIL both_we got %0b want 0", a_we); end
    n_cmp++; if (a_res !== 32'h2468ACE0 || a_stalls != 3) begin
      n_bad++; $display("FAIL both_data got %h stall=%0d want 2468ace0 3", a_res, a_stalls); end
  endtask

  task automatic test_back_to_back;
    int c1;
    do_access(1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 32'h11111111);
    c1 = a_cycles;
    n_cmp++; if (a_res !== 32'h11111111) begin n_bad++; $display("FAIL b2b_first got %h want 11111111", a_res); end
    do_access(1, 0, 3'b010, 32'h14, 32'h0, 0, 0, 32'h22222222);
    n_cmp++; if (a_res !== 32'h22222222) begin n_bad++; $display("FAIL b2b_second got %h want 22222222", a_res); end
    n_cmp++; if (c1 + a_cycles != 8) begin n_bad++; $display("FAIL b2b_cycles got %0d want 8", c1 + a_cycles); end
  endtask

  task automatic test_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
    do_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h99999999);
    n_cmp++; if (a_mis !== 1'b1) begin n_bad++; $display("FAIL mis_flag got %0b want 1", a_mis); end
    n_cmp++; if (a_vcyc != 0) begin n_bad++; $display("FAIL mis_noreq got %0d valid cycles want 0", a_vcyc); end
    n_cmp++; if (a_stalls != 0) begin n_bad++; $display("FAIL mis_stall got %0d want 0", a_stalls); end
    n_cmp++; if (r_Data_M !== 32'h22222222) begin n_bad++; $display("FAIL mis_rdata got %h want 22222222", r_Data_M); end
`else
    do_access(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11223344);
    n_cmp++; if (a_mis !== 1'b0) begin n_bad++; $display("FAIL mis_flag got %0b want 0", a_mis); end
    n_cmp++; if (a_addr !== 32'h100 || a_be !== 4'b1111) begin
      n_bad++; $display("FAIL mis_lw_req got addr=%h be=%b want 00000100 1111", a_addr, a_be); end
    n_cmp++; if (a_res !== 32'h11223344) begin n_bad++; $display("FAIL mis_lw_data got %h want 11223344", a_res); end
    do_access(1, 0, 3'b001, 32'h103, 32'h0, 0, 0, 32'hAABB1234);
    n_cmp++; if (a_be !== 4'b1100 || a_res !== 32'hFFFFAABB) begin
      n_bad++; $display("FAIL mis_lh got be=%b data=%h want 1100 ffffaabb", a_be, a_res); end
`endif
  endtask

  task automatic test_reset_wait;
    memRead_M = 1; funct3_M = 3'b010; addr_M = 32'h300;
    #1;
    n_cmp++; if (stall_M !== 1'b1) begin n_bad++; $display("FAIL rw_idle_stall got %0b want 1", stall_M); end
    @(negedge clk);
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rw_req_valid got %0b want 1", mem_req_valid); end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; memRead_M = 0; reset = 1;
    @(negedge clk);
    reset = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h12345678;
    #1;
    n_cmp++; if (stall_M !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL rw_after_reset got stall=%0b valid=%0b want 0 0", stall_M, mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 32'h0 || mem_req_be !== 4'h0 || r_Data_M !== 32'h0) begin
      n_bad++; $display("FAIL rw_outputs got addr=%h be=%b rdata=%h want 0", mem_req_addr, mem_req_be, r_Data_M); end
    @(negedge clk);
    mem_rsp_valid = 0;
    #1;
    n_cmp++; if (r_Data_M !== 32'h0 || stall_M !== 1'b0) begin
      n_bad++; $display("FAIL rw_rsp_ignored got rdata=%h stall=%0b want 0 0", r_Data_M, stall_M); end
    @(negedge clk);
  endtask

  initial begin
    reset = 1; memRead_M = 0; memWrite_M = 0; funct3_M = 0; addr_M = 0; wData_M = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_delays();
    test_load_wins();
    test_back_to_back();
    test_misalign();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
